// File: rtl/regfile_pkg.sv
// Shared defaults and types for the multi-port register file with scoreboard.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package regfile_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_NUM_RD   = 2;
  localparam int DEF_ADDR_W   = $clog2(DEF_NUM_REGS);

  typedef logic [DEF_ADDR_W-1:0] reg_idx_t;
  typedef logic [DEF_DATA_W-1:0] reg_data_t;

  // Number of registers that can actually hold data / become busy.
  function automatic int eff_regs(input int num_regs, input int zero_reg);
    return (zero_reg != 0) ? num_regs - 1 : num_regs;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One read port: zero-register check, write-first bypass, array mux, hazard flag.
// Latency: fully combinational, zero cycles.
// Backpressure: none; the port always answers.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int ZERO_REG = 1
) (
  input  logic [ADDR_W-1:0]   ra,
  input  logic [DATA_W-1:0]   regs [NUM_REGS],
  input  logic [NUM_REGS-1:0] busy,
  input  logic                wr_vld,
  input  logic [ADDR_W-1:0]   wa,
  input  logic [DATA_W-1:0]   wd,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_busy
);

  logic hit;

  // A write landing on the same register this cycle is visible immediately.
  assign hit = wr_vld && (wa == ra);

  // Zero register beats bypass, bypass beats stored value.
  always_comb begin
    rd_data = regs[ra];
    if ((ZERO_REG != 0) && (ra == '0)) begin
      rd_data = '0;
    end else if (hit) begin
      rd_data = wd;
    end
  end

  // The producer writing back now resolves the hazard in the same cycle.
  assign rd_busy = busy[ra] && !hit;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-read-port register file with write bypass and per-register busy scoreboard.
// Latency: reads combinational (0 cycles); writes, issue marks and counters update on the next edge.
// Backpressure: none; every write, issue and read is accepted every cycle.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wa,
  input  logic [DATA_W-1:0]        wd,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [ADDR_W:0]          busy_cnt,
  output logic                     sb_err
);

  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [ADDR_W:0]     busy_cnt_q;
  logic [ADDR_W:0]     busy_cnt_d;
  logic                sb_err_q;

  logic wr_vld;   // write request outside reset (drives the bypass)
  logic wr_ok;    // write that actually lands in storage
  logic set_ok;   // issue mark that actually lands in the scoreboard
  logic cnt_inc;
  logic cnt_dec;

  assign wr_vld  = we && !rst;
  assign wr_ok   = wr_vld && !((ZERO_REG != 0) && (wa == '0));
  assign set_ok  = iss_en && !rst && !((ZERO_REG != 0) && (iss_addr == '0));
  assign cnt_inc = set_ok && !busy_q[iss_addr];
  // A clear of a register that is simultaneously re-marked is superseded by the set.
  assign cnt_dec = wr_ok && busy_q[wa] && !(set_ok && (iss_addr == wa));

  // Next busy vector: clear from writeback first, then set from issue so set wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_ok) begin
      busy_d[wa] = 1'b0;
    end
    if (set_ok) begin
      busy_d[iss_addr] = 1'b1;
    end
  end

  // Incremental popcount tracking; net change is at most one either way.
  always_comb begin
    busy_cnt_d = busy_cnt_q;
    if (cnt_inc && !cnt_dec) begin
      busy_cnt_d = busy_cnt_q + CNT_ONE;
    end else if (cnt_dec && !cnt_inc) begin
      busy_cnt_d = busy_cnt_q - CNT_ONE;
    end
  end

  // Register storage with single writeback port.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_ok) begin
      regs_q[wa] <= wd;
    end
  end

  // Scoreboard, busy counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q     <= '0;
      busy_cnt_q <= '0;
      sb_err_q   <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
      if (wr_ok && !busy_q[wa]) begin
        sb_err_q <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    regfile_rd_port #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
    ) u_rd_port (
      .ra      (rd_addr[i*ADDR_W +: ADDR_W]),
      .regs    (regs_q),
      .busy    (busy_q),
      .wr_vld  (wr_vld),
      .wa      (wa),
      .wd      (wd),
      .rd_data (rd_data[i*DATA_W +: DATA_W]),
      .rd_busy (rd_busy[i])
    );
  end

  assign busy_cnt = busy_cnt_q;
  assign sb_err   = sb_err_q;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb: default 2R/32x32 instance plus a 4R/16x64 instance without zero register.
// Latency: n/a.
// Backpressure: n/a.
module tb_regfile_mp_sb;

  localparam int AW  = 5;
  localparam int DW  = 32;
  localparam int NR  = 32;
  localparam int NRD = 2;

  localparam int AW2  = 4;
  localparam int DW2  = 64;
  localparam int NR2  = 16;
  localparam int NRD2 = 4;

  logic clk = 1'b0;
  logic rst;

  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic              we;
  logic [AW-1:0]     wa;
  logic [DW-1:0]     wd;
  logic              iss_en;
  logic [AW-1:0]     iss_addr;
  logic [AW:0]       busy_cnt;
  logic              sb_err;

  logic [NRD2*AW2-1:0] w_rd_addr;
  logic [NRD2*DW2-1:0] w_rd_data;
  logic [NRD2-1:0]     w_rd_busy;
  logic                w_we;
  logic [AW2-1:0]      w_wa;
  logic [DW2-1:0]      w_wd;
  logic                w_iss_en;
  logic [AW2-1:0]      w_iss_addr;
  logic [AW2:0]        w_busy_cnt;
  logic                w_sb_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_mp_sb #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .we(we), .wa(wa), .wd(wd), .iss_en(iss_en), .iss_addr(iss_addr),
    .busy_cnt(busy_cnt), .sb_err(sb_err)
  );

  regfile_mp_sb #(.DATA_W(DW2), .NUM_REGS(NR2), .NUM_RD(NRD2), .ZERO_REG(0)) dut_w (
    .clk(clk), .rst(rst), .rd_addr(w_rd_addr), .rd_data(w_rd_data), .rd_busy(w_rd_busy),
    .we(w_we), .wa(w_wa), .wd(w_wd), .iss_en(w_iss_en), .iss_addr(w_iss_addr),
    .busy_cnt(w_busy_cnt), .sb_err(w_sb_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    we = 1'b0; wa = '0; wd = '0; iss_en = 1'b0; iss_addr = '0;
    w_we = 1'b0; w_wa = '0; w_wd = '0; w_iss_en = 1'b0; w_iss_addr = '0;
  endtask

  task automatic do_reset;
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rd_addr = '0; w_rd_addr = '0;
    do_reset();
    #1;
    total++;
    if (busy_cnt !== 6'd0) begin bad++; $display("FAIL reset_busy_cnt got=%0d exp=0", busy_cnt); end
    total++;
    if (sb_err !== 1'b0) begin bad++; $display("FAIL reset_sb_err got=%b exp=0", sb_err); end
    for (int a = 0; a < NR; a++) begin
      rd_addr = {AW'(NR - 1 - a), AW'(a)};
      #1;
      total++;
      if (rd_data !== 64'd0) begin bad++; $display("FAIL reset_rd_data addr=%0d got=%h exp=0", a, rd_data); end
      total++;
      if (rd_busy !== 2'b00) begin bad++; $display("FAIL reset_rd_busy addr=%0d got=%b exp=00", a, rd_busy); end
    end
  endtask

  task automatic test_write_bypass;
    we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
    rd_addr = {AW'(5), AW'(5)};
    #1;
    total++;
    if (rd_data[31:0] !== 32'hDEADBEEF) begin bad++; $display("FAIL bypass_p0 got=%h exp=deadbeef", rd_data[31:0]); end
    total++;
    if (rd_data[63:32] !== 32'hDEADBEEF) begin bad++; $display("FAIL bypass_p1 got=%h exp=deadbeef", rd_data[63:32]); end
    tick();
    idle();
    #1;
    total++;
    if (rd_data !== {2{32'hDEADBEEF}}) begin bad++; $display("FAIL stored_rd got=%h exp=deadbeefdeadbeef", rd_data); end
    we = 1'b1; wa = 5'd0; wd = 32'h1234;
    rd_addr = {AW'(0), AW'(0)};
    #1;
    total++;
    if (rd_data !== 64'd0) begin bad++; $display("FAIL zero_bypass got=%h exp=0", rd_data); end
    tick();
    idle();
    #1;
    total++;
    if (rd_data !== 64'd0) begin bad++; $display("FAIL zero_stored got=%h exp=0", rd_data); end
  endtask

  task automatic test_scoreboard;
    iss_en = 1'b1; iss_addr = 5'd7;
    rd_addr = {AW'(7), AW'(5)};
    #1;
    total++;
    if (rd_busy[1] !== 1'b0) begin bad++; $display("FAIL iss_same_cycle got=%b exp=0", rd_busy[1]); end
    tick();
    idle();
    #1;
    total++;
    if (rd_busy !== 2'b10) begin bad++; $display("FAIL iss_busy got=%b exp=10", rd_busy); end
    total++;
    if (busy_cnt !== 6'd1) begin bad++; $display("FAIL iss_cnt got=%0d exp=1", busy_cnt); end
    we = 1'b1; wa = 5'd7; wd = 32'h55;
    #1;
    total++;
    if (rd_busy[1] !== 1'b0) begin bad++; $display("FAIL wb_resolve got=%b exp=0", rd_busy[1]); end
    total++;
    if (rd_data[63:32] !== 32'h55) begin bad++; $display("FAIL wb_bypass got=%h exp=55", rd_data[63:32]); end
    tick();
    idle();
    #1;
    total++;
    if (busy_cnt !== 6'd0) begin bad++; $display("FAIL wb_cnt got=%0d exp=0", busy_cnt); end
    total++;
    if (rd_data[63:32] !== 32'h55) begin bad++; $display("FAIL wb_stored got=%h exp=55", rd_data[63:32]); end
  endtask

  task automatic test_set_clear;
    iss_en = 1'b1; iss_addr = 5'd9;
    tick();
    iss_en = 1'b1; iss_addr = 5'd9; we = 1'b1; wa = 5'd9; wd = 32'h99;
    tick();
    idle();
    rd_addr = {AW'(9), AW'(9)};
    #1;
    total++;
    if (rd_busy !== 2'b11) begin bad++; $display("FAIL same_addr_busy got=%b exp=11", rd_busy); end
    total++;
    if (busy_cnt !== 6'd1) begin bad++; $display("FAIL same_addr_cnt got=%0d exp=1", busy_cnt); end
    total++;
    if (rd_data[31:0] !== 32'h99) begin bad++; $display("FAIL same_addr_data got=%h exp=99", rd_data[31:0]); end
    iss_en = 1'b1; iss_addr = 5'd4;
    tick();
    idle();
    #1;
    total++;
    if (busy_cnt !== 6'd2) begin bad++; $display("FAIL set4_cnt got=%0d exp=2", busy_cnt); end
    iss_en = 1'b1; iss_addr = 5'd3; we = 1'b1; wa = 5'd4; wd = 32'h44;
    tick();
    idle();
    rd_addr = {AW'(4), AW'(3)};
    #1;
    total++;
    if (rd_busy !== 2'b01) begin bad++; $display("FAIL move_busy got=%b exp=01", rd_busy); end
    total++;
    if (busy_cnt !== 6'd2) begin bad++; $display("FAIL move_cnt got=%0d exp=2", busy_cnt); end
    total++;
    if (rd_data[63:32] !== 32'h44) begin bad++; $display("FAIL move_data got=%h exp=44", rd_data[63:32]); end
    // Register 0 never becomes busy.
    iss_en = 1'b1; iss_addr = 5'd0;
    tick();
    idle();
    rd_addr = {AW'(0), AW'(0)};
    #1;
    total++;
    if (busy_cnt !== 6'd2) begin bad++; $display("FAIL zero_iss_cnt got=%0d exp=2", busy_cnt); end
    total++;
    if (rd_busy !== 2'b00) begin bad++; $display("FAIL zero_iss_busy got=%b exp=00", rd_busy); end
  endtask

  task automatic test_sb_err_reset;
    do_reset();
    #1;
    total++;
    if (sb_err !== 1'b0) begin bad++; $display("FAIL err_clear got=%b exp=0", sb_err); end
    we = 1'b1; wa = 5'd12; wd = 32'h1;
    tick();
    idle();
    #1;
    total++;
    if (sb_err !== 1'b1) begin bad++; $display("FAIL err_set got=%b exp=1", sb_err); end
    tick();
    total++;
    if (sb_err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", sb_err); end
    for (int r = 1; r <= 10; r++) begin
      iss_en = 1'b1; iss_addr = AW'(r);
      tick();
    end
    idle();
    rd_addr = {AW'(10), AW'(3)};
    #1;
    total++;
    if (busy_cnt !== 6'd10) begin bad++; $display("FAIL ten_cnt got=%0d exp=10", busy_cnt); end
    total++;
    if (rd_busy !== 2'b11) begin bad++; $display("FAIL ten_busy got=%b exp=11", rd_busy); end
    rst = 1'b1;
    we = 1'b1; wa = 5'd3; wd = 32'hABC;
    iss_en = 1'b1; iss_addr = 5'd20;
    rd_addr = {AW'(12), AW'(3)};
    #1;
    total++;
    if (rd_data !== {32'h1, 32'h0}) begin bad++; $display("FAIL rst_no_bypass got=%h exp=0000000100000000", rd_data); end
    total++;
    if (rd_busy[0] !== 1'b1) begin bad++; $display("FAIL rst_busy_hold got=%b exp=1", rd_busy[0]); end
    tick();
    rst = 1'b0;
    idle();
    #1;
    total++;
    if (busy_cnt !== 6'd0) begin bad++; $display("FAIL post_rst_cnt got=%0d exp=0", busy_cnt); end
    total++;
    if (sb_err !== 1'b0) begin bad++; $display("FAIL post_rst_err got=%b exp=0", sb_err); end
    total++;
    if (rd_busy !== 2'b00) begin bad++; $display("FAIL post_rst_busy got=%b exp=00", rd_busy); end
    total++;
    if (rd_data !== 64'd0) begin bad++; $display("FAIL post_rst_data got=%h exp=0", rd_data); end
  endtask

  task automatic test_full;
    for (int r = 0; r < NR; r++) begin
      iss_en = 1'b1; iss_addr = AW'(r);
      tick();
    end
    idle();
    rd_addr = {AW'(31), AW'(0)};
    #1;
    total++;
    if (busy_cnt !== 6'd31) begin bad++; $display("FAIL full_cnt got=%0d exp=31", busy_cnt); end
    total++;
    if (rd_busy !== 2'b10) begin bad++; $display("FAIL full_busy got=%b exp=10", rd_busy); end
    we = 1'b1; wa = 5'd31; wd = 32'h31;
    tick();
    idle();
    #1;
    total++;
    if (busy_cnt !== 6'd30) begin bad++; $display("FAIL full_dec_cnt got=%0d exp=30", busy_cnt); end
    total++;
    if (sb_err !== 1'b0) begin bad++; $display("FAIL full_err got=%b exp=0", sb_err); end
  endtask

  task automatic test_wide;
    logic [DW2-1:0] pat_a;
    logic [DW2-1:0] pat_b;
    pat_a = 64'hFFFF_0000_FFFF_0000;
    pat_b = 64'h0123_4567_89AB_CDEF;
    do_reset();
    w_rd_addr = '0;
    w_we = 1'b1; w_wa = 4'd0; w_wd = pat_a;
    #1;
    for (int p = 0; p < NRD2; p++) begin
      total++;
      if (w_rd_data[p*DW2 +: DW2] !== pat_a) begin bad++; $display("FAIL wide_bypass port=%0d got=%h exp=%h", p, w_rd_data[p*DW2 +: DW2], pat_a); end
    end
    tick();
    idle();
    #1;
    for (int p = 0; p < NRD2; p++) begin
      total++;
      if (w_rd_data[p*DW2 +: DW2] !== pat_a) begin bad++; $display("FAIL wide_stored port=%0d got=%h exp=%h", p, w_rd_data[p*DW2 +: DW2], pat_a); end
    end
    total++;
    if (w_sb_err !== 1'b1) begin bad++; $display("FAIL wide_err got=%b exp=1", w_sb_err); end
    w_iss_en = 1'b1; w_iss_addr = 4'd0;
    tick();
    idle();
    #1;
    total++;
    if (w_busy_cnt !== 5'd1) begin bad++; $display("FAIL wide_cnt got=%0d exp=1", w_busy_cnt); end
    total++;
    if (w_rd_busy !== 4'hF) begin bad++; $display("FAIL wide_busy got=%b exp=1111", w_rd_busy); end
    w_we = 1'b1; w_wa = 4'd15; w_wd = pat_b;
    tick();
    idle();
    w_rd_addr = {AW2'(15), AW2'(0), AW2'(15), AW2'(0)};
    #1;
    total++;
    if (w_rd_data !== {pat_b, pat_a, pat_b, pat_a}) begin bad++; $display("FAIL wide_mix got=%h exp=%h", w_rd_data, {pat_b, pat_a, pat_b, pat_a}); end
    total++;
    if (w_rd_busy !== 4'b0101) begin bad++; $display("FAIL wide_mix_busy got=%b exp=0101", w_rd_busy); end
  endtask

  initial begin
    rst = 1'b0;
    rd_addr = '0;
    w_rd_addr = '0;
    idle();
    test_reset();
    test_write_bypass();
    test_scoreboard();
    test_set_clear();
    test_sb_err_reset();
    test_full();
    test_wide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
